// File: rtl/wb_dec_pkg.sv
// Shared types and default memory map for the Wishbone address decoder.
// Slave index 0 is the rightmost element of each packed constant.
package wb_dec_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        DECERR = 2'd2,
        TMOERR = 2'd3
    } dec_state_t;

    localparam int DEF_N_SLAVES = 4;
    localparam int DEF_ADDR_W   = 32;
    localparam int DEF_DATA_W   = 32;
    localparam int DEF_TIMEOUT  = 255;

    // System map: RAM at 0x0000_xxxx, UART 0x1xxx_xxxx, timer 0x2xxx_xxxx, GPIO upper half.
    localparam logic [DEF_N_SLAVES-1:0][DEF_ADDR_W-1:0] DEF_SLAVE_BASE = {
        32'h8000_0000, 32'h2000_0000, 32'h1000_0000, 32'h0000_0000
    };
    localparam logic [DEF_N_SLAVES-1:0][DEF_ADDR_W-1:0] DEF_SLAVE_MASK = {
        32'h8000_0000, 32'hF000_0000, 32'hF000_0000, 32'hFFFF_0000
    };

    localparam int TMO_W = $clog2(DEF_TIMEOUT + 1);

    function automatic int tmo_width(input int timeout);
        return (timeout < 1) ? 1 : $clog2(timeout + 1);
    endfunction

    function automatic int sel_width(input int n_slaves);
        return (n_slaves > 1) ? $clog2(n_slaves) : 1;
    endfunction

endpackage

// File: rtl/wb_addr_decoder_if.sv
// Wishbone B4 classic bus bundle between the upstream master/mux and the decoder.
interface wb_addr_decoder_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              cyc;
    logic              stb;
    logic              we;
    logic [ADDR_W-1:0] adr;
    logic [DATA_W-1:0] dat_o;
    logic [DATA_W-1:0] dat_i;
    logic              ack;
    logic              err;
    logic              rty;

    modport master (
        output cyc, stb, we, adr, dat_o,
        input  dat_i, ack, err, rty
    );

    modport slave (
        input  cyc, stb, we, adr, dat_o,
        output dat_i, ack, err, rty
    );

endinterface

// File: rtl/wb_addr_match.sv
// Combinational address compare against every slave window; the lowest
// matching index wins so overlapping windows resolve deterministically.
module wb_addr_match
    import wb_dec_pkg::*;
#(
    parameter int N_SLAVES   = DEF_N_SLAVES,
    parameter int ADDR_W     = DEF_ADDR_W,
    localparam int SEL_W     = sel_width(N_SLAVES)
) (
    input  logic [ADDR_W-1:0]                 i_adr,
    input  logic [N_SLAVES-1:0][ADDR_W-1:0]   i_base,
    input  logic [N_SLAVES-1:0][ADDR_W-1:0]   i_mask,
    output logic                              o_hit,
    output logic [SEL_W-1:0]                  o_idx
);

    always_comb begin
        o_hit = 1'b0;
        o_idx = '0;
        // Walk downwards so a lower index overwrites any higher match.
        for (int i = N_SLAVES - 1; i >= 0; i--) begin
            if ((i_adr & i_mask[i]) == i_base[i]) begin
                o_hit = 1'b1;
                o_idx = SEL_W'(i);
            end
        end
    end

endmodule

// File: rtl/wb_addr_decoder.sv
// Wishbone B4 single-master to N-slave decoder: one-cycle decode, routed
// transfer, and ERR termination of unmapped or stalled accesses.
//
//   state  | meaning
//   IDLE   | no transfer routed; decode ADR on CYC&STB and latch the slave index
//   ACTIVE | selected slave sees CYC/STB live; wait for ACK/ERR/RTY, abort or timeout
//   DECERR | address hit no window; one-cycle ERR upstream
//   TMOERR | selected slave stalled too long; one-cycle ERR upstream
module wb_addr_decoder
    import wb_dec_pkg::*;
#(
    parameter int N_SLAVES = DEF_N_SLAVES,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int DATA_W   = DEF_DATA_W,
    parameter logic [N_SLAVES-1:0][ADDR_W-1:0] SLAVE_BASE = DEF_SLAVE_BASE,
    parameter logic [N_SLAVES-1:0][ADDR_W-1:0] SLAVE_MASK = DEF_SLAVE_MASK,
    parameter int TIMEOUT  = DEF_TIMEOUT
) (
    input  logic                         clk,
    input  logic                         rst,
    wb_addr_decoder_if.slave             bus_in,
    output logic [N_SLAVES-1:0]          s_cyc,
    output logic [N_SLAVES-1:0]          s_stb,
    output logic                         s_we,
    output logic [ADDR_W-1:0]            s_adr,
    output logic [DATA_W-1:0]            s_dat_o,
    input  logic [N_SLAVES*DATA_W-1:0]   s_dat_i,
    input  logic [N_SLAVES-1:0]          s_ack,
    input  logic [N_SLAVES-1:0]          s_err,
    input  logic [N_SLAVES-1:0]          s_rty
);

    localparam int SEL_W     = sel_width(N_SLAVES);
    localparam int TMO_CNT_W = tmo_width(TIMEOUT);
    localparam logic [TMO_CNT_W-1:0] TMO_LAST = TMO_CNT_W'(TIMEOUT - 1);
    localparam logic [TMO_CNT_W-1:0] TMO_MAX  = TMO_CNT_W'(TIMEOUT);

    dec_state_t             r_state;
    dec_state_t             w_state_nxt;
    logic [SEL_W-1:0]       r_sel;
    logic [TMO_CNT_W-1:0]   r_tmo_cnt;

    logic                   w_hit;
    logic [SEL_W-1:0]       w_match_idx;
    logic                   w_req;
    logic                   w_sel_resp;
    logic                   w_tmo_hit;
    logic [DATA_W-1:0]      w_slv_dat [N_SLAVES];

    wb_addr_match #(
        .N_SLAVES (N_SLAVES),
        .ADDR_W   (ADDR_W)
    ) u_match (
        .i_adr  (bus_in.adr),
        .i_base (SLAVE_BASE),
        .i_mask (SLAVE_MASK),
        .o_hit  (w_hit),
        .o_idx  (w_match_idx)
    );

    for (genvar g = 0; g < N_SLAVES; g++) begin : g_unpack
        assign w_slv_dat[g] = s_dat_i[g*DATA_W +: DATA_W];
    end

    assign w_req      = bus_in.cyc && bus_in.stb;
    assign w_sel_resp = s_ack[r_sel] || s_err[r_sel] || s_rty[r_sel];
    // Timeout fires on the last stalled cycle, so STB is held exactly TIMEOUT cycles.
    assign w_tmo_hit  = (r_tmo_cnt == TMO_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_sel   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == IDLE && w_req) begin
                r_sel <= w_match_idx;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tmo_cnt <= '0;
        end else if (r_state == ACTIVE && bus_in.cyc && !w_sel_resp) begin
            if (r_tmo_cnt != TMO_MAX) begin
                r_tmo_cnt <= r_tmo_cnt + 1'b1;
            end
        end else begin
            r_tmo_cnt <= '0;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        s_cyc        = '0;
        s_stb        = '0;
        s_we         = 1'b0;
        s_adr        = '0;
        s_dat_o      = '0;
        bus_in.dat_i = '0;
        bus_in.ack   = 1'b0;
        bus_in.err   = 1'b0;
        bus_in.rty   = 1'b0;

        case (r_state)
            IDLE: begin
                if (w_req) begin
                    w_state_nxt = w_hit ? ACTIVE : DECERR;
                end
            end

            ACTIVE: begin
                s_cyc[r_sel] = bus_in.cyc;
                s_stb[r_sel] = bus_in.stb;
                s_we         = bus_in.we;
                s_adr        = bus_in.adr;
                s_dat_o      = bus_in.dat_o;
                bus_in.dat_i = w_slv_dat[r_sel];
                // A master abort suppresses any late slave response.
                if (bus_in.cyc) begin
                    bus_in.ack = s_ack[r_sel];
                    bus_in.err = s_err[r_sel];
                    bus_in.rty = s_rty[r_sel];
                end

                if (!bus_in.cyc) begin
                    w_state_nxt = IDLE;
                end else if (w_sel_resp) begin
                    w_state_nxt = IDLE;
                end else if (w_tmo_hit) begin
                    w_state_nxt = TMOERR;
                end
            end

            DECERR, TMOERR: begin
                bus_in.err  = 1'b1;
                w_state_nxt = IDLE;
            end

            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    a_one_stb: assert property (@(posedge clk) disable iff (rst) $onehot0(s_stb));

endmodule

// File: tb/tb_wb_addr_decoder.sv
// Directed bench for wb_addr_decoder: routing, decode/timeout errors, abort, reset
// and priority, with scripted slave models and hand-computed expectations.
module tb_wb_addr_decoder;
    import wb_dec_pkg::*;

    logic        clk;
    logic        rst;
    logic [3:0]  s_cyc;
    logic [3:0]  s_stb;
    logic        s_we;
    logic [31:0] s_adr;
    logic [31:0] s_dat_o;
    logic [127:0] s_dat_i;
    logic [3:0]  s_ack;
    logic [3:0]  s_err;
    logic [3:0]  s_rty;

    wb_addr_decoder_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    wb_addr_decoder #(
        .N_SLAVES (4),
        .ADDR_W   (32),
        .DATA_W   (32),
        .TIMEOUT  (8)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .bus_in  (bus),
        .s_cyc   (s_cyc),
        .s_stb   (s_stb),
        .s_we    (s_we),
        .s_adr   (s_adr),
        .s_dat_o (s_dat_o),
        .s_dat_i (s_dat_i),
        .s_ack   (s_ack),
        .s_err   (s_err),
        .s_rty   (s_rty)
    );

    // Overlapping map: slave 1 matches everything, so lowest index must win.
    localparam logic [3:0][31:0] OVL_BASE = {32'h8000_0000, 32'h2000_0000, 32'h0000_0000, 32'h0000_0000};
    localparam logic [3:0][31:0] OVL_MASK = {32'h8000_0000, 32'hF000_0000, 32'h0000_0000, 32'hFFFF_0000};
    logic [31:0] ovl_adr;
    logic        ovl_hit;
    logic [1:0]  ovl_idx;

    wb_addr_match #(.N_SLAVES(4), .ADDR_W(32)) u_ovl (
        .i_adr  (ovl_adr),
        .i_base (OVL_BASE),
        .i_mask (OVL_MASK),
        .o_hit  (ovl_hit),
        .o_idx  (ovl_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Slave models: respond when STB has been held lat[i] edges; mode 0=ACK 1=ERR 2=RTY.
    int          lat   [4];
    int          mode  [4];
    int          cnt   [4];
    logic [31:0] rdata [4];
    logic [3:0]  spur;

    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            cnt[i] <= (s_cyc[i] && s_stb[i]) ? cnt[i] + 1 : 0;
        end
    end

    always_comb begin
        s_ack   = '0;
        s_err   = '0;
        s_rty   = '0;
        s_dat_i = '0;
        for (int i = 0; i < 4; i++) begin
            s_dat_i[i*32 +: 32] = rdata[i];
            if (s_cyc[i] && s_stb[i] && cnt[i] == lat[i]) begin
                s_ack[i] = (mode[i] == 0);
                s_err[i] = (mode[i] == 1);
                s_rty[i] = (mode[i] == 2);
            end
            s_ack[i] = s_ack[i] | spur[i];
        end
    end

    int overlap_cnt;
    always @(negedge clk) begin
        if (!$onehot0(s_stb)) overlap_cnt++;
    end

    int n_chk;
    int n_pass;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        else n_pass++;
    endtask

    int          x_at;
    logic [2:0]  x_resp;
    logic [31:0] x_rdat;
    logic [3:0]  x_stb_seen;
    int          x_stb1;
    logic [31:0] x_adr;
    logic        x_we;
    logic [31:0] x_dat;

    // Called just after a rising edge; returns just after the edge that completes the beat.
    task automatic do_xfer(input logic [31:0] adr, input logic we, input logic [31:0] wdat);
        x_at = -1; x_resp = '0; x_rdat = '0; x_stb_seen = '0; x_stb1 = 0;
        x_adr = '0; x_we = 1'b0; x_dat = '0;
        bus.cyc = 1'b1; bus.stb = 1'b1; bus.we = we; bus.adr = adr; bus.dat_o = wdat;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            x_stb_seen |= s_stb;
            if (s_stb[1]) x_stb1++;
            if (|s_stb) begin
                x_adr = s_adr; x_we = s_we; x_dat = s_dat_o;
            end
            if (bus.ack || bus.err || bus.rty) begin
                x_at   = n;
                x_resp = {bus.ack, bus.err, bus.rty};
                x_rdat = bus.dat_i;
                break;
            end
        end
        @(posedge clk); #1;
        bus.cyc = 1'b0; bus.stb = 1'b0; bus.we = 1'b0; bus.adr = '0; bus.dat_o = '0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_s_strobes"}, {s_cyc, s_stb, s_we}, '0);
        chk({tag, "_s_adr_dat"}, {s_adr, s_dat_o}, '0);
        chk({tag, "_up_resp"}, {bus.dat_i, bus.ack, bus.err, bus.rty}, '0);
        chk({tag, "_state"}, 64'(dut.r_state), 64'(IDLE));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    logic [2:0] late_resp;

    initial begin
        n_chk = 0; n_pass = 0; overlap_cnt = 0; spur = '0;
        for (int i = 0; i < 4; i++) begin
            lat[i] = 0; mode[i] = 0;
        end
        rdata[0] = 32'h0000_A000; rdata[1] = 32'h1111_1111;
        rdata[2] = 32'hDEAD_BEEF; rdata[3] = 32'h3333_3333;
        bus.cyc = 1'b0; bus.stb = 1'b0; bus.we = 1'b0; bus.adr = '0; bus.dat_o = '0;
        ovl_adr = '0;
        rst = 1'b1;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_all_zero("reset");

        // Priority on an overlapping map (pure combinational matcher).
        ovl_adr = 32'h0000_0004; #1;
        chk("ovl_low_idx", {ovl_hit, ovl_idx}, {1'b1, 2'd0});
        ovl_adr = 32'h4000_0000; #1;
        chk("ovl_catchall", {ovl_hit, ovl_idx}, {1'b1, 2'd1});
        ovl_adr = 32'h9000_0000; #1;
        chk("ovl_1_over_3", {ovl_hit, ovl_idx}, {1'b1, 2'd1});

        @(posedge clk); #1;
        rst = 1'b0;

        // Read slave 2 with 2-cycle latency; stray ACKs on slaves 0/1 must be ignored.
        lat[2] = 2; spur = 4'b0011;
        do_xfer(32'h2000_0010, 1'b0, 32'h0);
        spur = '0;
        chk("rd2_latency", x_at, 4);
        chk("rd2_resp", x_resp, 3'b100);
        chk("rd2_data", x_rdat, 32'hDEAD_BEEF);
        chk("rd2_stb_seen", x_stb_seen, 4'b0100);
        chk("rd2_s_adr", x_adr, 32'h2000_0010);

        // Unmapped address.
        do_xfer(32'h4000_0000, 1'b0, 32'h0);
        chk("decerr_latency", x_at, 2);
        chk("decerr_resp", x_resp, 3'b010);
        chk("decerr_dat", x_rdat, 32'h0);
        chk("decerr_stb_seen", x_stb_seen, 4'b0000);
        @(negedge clk);
        chk("decerr_one_cycle", bus.err, 1'b0);
        @(posedge clk); #1;

        // Single-window hits on slave 0 and slave 3.
        lat[0] = 0; lat[3] = 0;
        do_xfer(32'h0000_0004, 1'b0, 32'h0);
        chk("rd0_stb_seen", x_stb_seen, 4'b0001);
        chk("rd0_data", {x_at[7:0], x_rdat}, {8'd2, 32'h0000_A000});
        do_xfer(32'h9000_0000, 1'b0, 32'h0);
        chk("rd3_stb_seen", x_stb_seen, 4'b1000);
        chk("rd3_data", {x_at[7:0], x_rdat}, {8'd2, 32'h3333_3333});

        // Slave 1 never answers: STB held 8 cycles, then one ERR.
        lat[1] = -1;
        do_xfer(32'h1000_0000, 1'b0, 32'h0);
        chk("tmo_latency", x_at, 10);
        chk("tmo_resp", x_resp, 3'b010);
        chk("tmo_stb1_cycles", x_stb1, 8);
        chk("tmo_dat", x_rdat, 32'h0);
        @(negedge clk);
        chk("tmo_err_one_cycle", bus.err, 1'b0);
        @(posedge clk); #1;
        do_xfer(32'h0000_0008, 1'b0, 32'h0);
        chk("after_tmo_rd0", {x_at[7:0], x_resp, x_rdat}, {8'd2, 3'b100, 32'h0000_A000});

        // Abort three cycles into a slave-2 stall.
        lat[2] = -1;
        bus.cyc = 1'b1; bus.stb = 1'b1; bus.adr = 32'h2000_0000;
        repeat (4) @(negedge clk);
        chk("abort_pre_stb", s_stb, 4'b0100);
        @(posedge clk); #1;
        bus.cyc = 1'b0; bus.stb = 1'b0; bus.adr = '0;
        @(negedge clk);
        chk("abort_s_cyc", {s_cyc, s_stb}, 8'h00);
        late_resp = {bus.ack, bus.err, bus.rty};
        repeat (3) begin
            @(negedge clk);
            late_resp |= {bus.ack, bus.err, bus.rty};
        end
        chk("abort_no_resp", late_resp, 3'b000);
        chk("abort_state", 64'(dut.r_state), 64'(IDLE));

        // Reset in the middle of a stalled write.
        @(posedge clk); #1;
        bus.cyc = 1'b1; bus.stb = 1'b1; bus.we = 1'b1; bus.adr = 32'h2000_0020; bus.dat_o = 32'h5555_AAAA;
        repeat (3) @(negedge clk);
        chk("rstmid_pre", {s_stb, s_we, s_dat_o}, {4'b0100, 1'b1, 32'h5555_AAAA});
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk_all_zero("rstmid");
        bus.cyc = 1'b0; bus.stb = 1'b0; bus.we = 1'b0; bus.adr = '0; bus.dat_o = '0;
        @(posedge clk); #1;
        rst = 1'b0;

        // Back-to-back: write slave 0 then read slave 3, both zero-wait.
        lat[2] = 2;
        do_xfer(32'h0000_0100, 1'b1, 32'hCAFE_0001);
        chk("b2b_wr_latency", x_at, 2);
        chk("b2b_wr_bus", {x_stb_seen, x_we, x_dat}, {4'b0001, 1'b1, 32'hCAFE_0001});
        do_xfer(32'h8000_0040, 1'b0, 32'h0);
        chk("b2b_rd_latency", x_at, 2);
        chk("b2b_rd_bus", {x_stb_seen, x_we, x_rdat}, {4'b1000, 1'b0, 32'h3333_3333});

        // RTY and ERR from slaves are passed through unchanged.
        mode[3] = 2; lat[3] = 1;
        do_xfer(32'h8000_0000, 1'b0, 32'h0);
        chk("rty3", {x_at[7:0], x_resp}, {8'd3, 3'b001});
        mode[1] = 1; lat[1] = 0;
        do_xfer(32'h1000_0004, 1'b1, 32'h1);
        chk("err1", {x_at[7:0], x_resp}, {8'd2, 3'b010});

        chk("no_stb_overlap", overlap_cnt, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/wb_addr_decoder.md
Name: wb_addr_decoder

Overview:
- Wishbone B4 single-master to N-slave address decoder; the fan-out counterpart of the bus multiplexer.
- Sits between the muxed core bus and peripheral slaves (RAM, UART, timer, GPIO).
- Routes each cycle to exactly one slave by address, and returns that slave's response.
- Terminates unmapped accesses and hung slaves with ERR.

Parameters:
- N_SLAVES, 4, number of downstream slaves (1..8).
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- SLAVE_BASE, {32'h8000_0000, 32'h2000_0000, 32'h1000_0000, 32'h0000_0000}, per-slave base address; index 0 is the rightmost element.
- SLAVE_MASK, {32'h8000_0000, 32'hF000_0000, 32'hF000_0000, 32'hFFFF_0000}, per-slave compare mask; slave i matches when (ADR & MASK[i]) == BASE[i].
- TIMEOUT, 255, cycles an active slave may stall before the decoder forces ERR.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- bus_in  WB4.slave  -  upstream bus from master/mux: STB, CYC, WE, ADR, DAT_O in; DAT_I, ACK, ERR, RTY out
- s_cyc  out  N_SLAVES  per-slave CYC
- s_stb  out  N_SLAVES  per-slave STB
- s_we  out  1  shared WE
- s_adr  out  ADR_W  shared address
- s_dat_o  out  DATA_W  shared write data
- s_dat_i  in  N_SLAVES*DATA_W  per-slave read data, slave i at [i*DATA_W +: DATA_W]
- s_ack  in  N_SLAVES  per-slave ACK
- s_err  in  N_SLAVES  per-slave ERR
- s_rty  in  N_SLAVES  per-slave RTY

Behaviour:
- Reset (synchronous, rst=1 at clk edge):
  - state=IDLE; sel=0; tmo_cnt=0.
  - All outputs 0: s_cyc, s_stb, s_we, s_adr, s_dat_o, bus_in.DAT_I/ACK/ERR/RTY.
  - Reset mid-transaction aborts without any upstream response.
- State IDLE:
  - All slave strobes and upstream responses are 0.
  - On CYC&STB, decode ADR: lowest matching index wins; register it into sel.
  - Match: go ACTIVE. No match: go DECERR.
  - Decode costs exactly one cycle.
- State ACTIVE:
  - s_cyc[sel] and s_stb[sel] follow bus_in.CYC/STB combinationally; all other slaves see 0.
  - s_we, s_adr and s_dat_o pass through live.
  - bus_in.DAT_I/ACK/ERR/RTY are taken from slave sel.
  - tmo_cnt increments each cycle without ACK/ERR/RTY; it saturates and does not wrap.
  - On ACK, ERR or RTY from slave sel: pass it upstream that same cycle, clear tmo_cnt, go IDLE.
  - tmo_cnt reaching TIMEOUT with no response: drop s_cyc/s_stb, go TMOERR.
  - Upstream CYC=0 (abort): drop downstream that cycle, clear tmo_cnt, go IDLE, no response.
  - A response arriving in the same cycle as the timeout wins; the slave response is passed, not ERR.
- State DECERR / TMOERR:
  - bus_in.ERR=1 for exactly one cycle; DAT_I=0.
  - Next state is IDLE.
  - ERR is issued even if upstream CYC drops that cycle, and is harmless to the master.
- Back-to-back or block accesses:
  - Each beat returns through IDLE and is re-decoded.
  - Per-beat latency = 1 decode cycle + slave latency.
  - Consecutive beats may target different slaves.
- Responses on non-selected s_ack/s_err/s_rty are ignored in every state.
- At most one s_stb bit is ever high; this is asserted in simulation.

Decomposition:
- Package wb_dec_pkg:
  - state enum dec_state_t {IDLE, ACTIVE, DECERR, TMOERR}.
  - Default base/mask constants for the system memory map.
  - Localparam for tmo_cnt width, $clog2(TIMEOUT+1).
- Sub-module wb_addr_match: purely combinational. Takes ADR, BASE and MASK arrays; outputs hit and the index of the lowest match.
- The decoder FSM, timeout counter and routing stay in wb_addr_decoder.

Test Plan:
- Read slave 2: ADR=0x2000_0010, WE=0, slave 2 ACKs 2 cycles after its STB with 0xDEAD_BEEF -> only s_stb[2] high; bus_in.ACK=1 with DAT_I=0xDEAD_BEEF 4 cycles after request; no other s_stb ever high.
- Unmapped address: ADR=0x4000_0000 -> no s_stb asserted; bus_in.ERR=1 for exactly one cycle, 2 cycles after request; DAT_I=0.
- Priority overlap: ADR=0x0000_0004 matches slaves 0 and... only slave 0; ADR=0x9000_0000 matches slave 3 only; set SLAVE_MASK[1]=0 -> ADR=0x0000_0004 goes to slave 0 (lowest index).
- Timeout: TIMEOUT=8, slave 1 never responds to ADR=0x1000_0000 -> s_stb[1] high 8 cycles then low; bus_in.ERR pulses once; next request to slave 0 completes normally.
- Abort and reset: drop CYC 3 cycles into slave-2 stall -> s_cyc all 0 next cycle, no ACK/ERR upstream. Repeat with rst=1 mid-transaction -> all outputs 0 after the edge, state IDLE.
- Back-to-back write slave 0 then read slave 3 with zero-wait slaves -> each beat ACKed 2 cycles after STB; s_stb[0] and s_stb[3] never overlap.
